ref_clk_gen: RTL and testbench
==============================

Name: ref_clk_gen

Overview:
Programmable reference-clock transmitter for the ADPLL bench and the on-FPGA loop. It runs on the FPGA clock and drives the reference input of the phase detector. The half-period is programmable and glitch-free, and signed phase steps can be injected to exercise lock acquisition and the loop filter's step response. The block sits beside the PLL and shares the PLL's reset.

Parameters:
PERIOD_WIDTH, 16, width of the half-period setting and the phase counter.
DEFAULT_HALF, 16'd50, half-period in fpga_clk_i cycles after reset.
STEP_WIDTH, 8, width of the signed phase-step input.
EDGE_CNT_WIDTH, 16, width of the rising-edge counter.

Ports:
fpga_clk_i  in  1  single system clock; all logic is on its rising edge.
reset_i  in  1  asynchronous, active-high reset.
enable_i  in  1  run request.
half_period_i  in  PERIOD_WIDTH  new half-period in cycles; unsigned.
load_i  in  1  one-cycle request to adopt half_period_i.
load_ack_o  out  1  one-cycle pulse when the new half-period takes effect.
phase_step_i  in  STEP_WIDTH  signed phase step, in cycles.
step_valid_i  in  1  phase-step request.
step_ready_o  out  1  step slot free; transfer occurs when valid and ready are both high.
ref_clk_o  out  1  generated reference clock, registered.
edge_o  out  1  one-cycle pulse in the cycle ref_clk_o first reads 1.
edge_cnt_o  out  EDGE_CNT_WIDTH  count of rising edges; wraps modulo 2^EDGE_CNT_WIDTH.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, ref_clk_o=0, edge_o=0, load_ack_o=0, edge_cnt_o=0, step_ready_o=1, half_q=DEFAULT_HALF. Pending load and pending step are cleared.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: ref_clk_o=0. If enable_i=1, the next cycle is HIGH with ref_clk_o=1 and edge_o=1. First edge comes 1 cycle after enable_i is sampled.
  - HIGH: lasts half_q cycles, then goes to LOW.
  - LOW: lasts L cycles. At the end of LOW, go to HIGH (with a rising edge) if enable_i=1, else go to IDLE.
- Dropping enable_i mid-period never truncates a phase. No runt pulses.
- Phase counter: counts 0..len-1 within each phase and is cleared on every transition.
- Half-period clamp: a half_period_i of 0 is stored as 1. Period = 2*half_q when no step is applied.
- Load path:
  - load_i captures half_period_i into pend_half and sets load_pend.
  - A second load_i before application overwrites pend_half. Only one ack is issued, for the last value.
  - Application happens at the next IDLE->HIGH or LOW->HIGH transition. In that same cycle half_q<=pend_half, load_pend clears and load_ack_o=1.
  - In IDLE with enable_i=0, the load applies on the cycle after capture, with an ack.
- Step path:
  - step_ready_o=0 from the cycle after acceptance until the end of the LOW phase that consumes the step.
  - The accepted step applies to the next LOW phase entered. A step accepted during LOW waits for the following LOW.
  - L = max(1, half_q + step), computed signed at PERIOD_WIDTH+2 bits, then saturated to 2^PERIOD_WIDTH-1.
  - A positive step delays the next rising edge. A negative step advances it.
  - Without a step, L = half_q.
- Simultaneous load and step: both are accepted. The LOW phase that consumes the step uses the half_q in force when LOW is entered, i.e. the new half-period if the load applied at the preceding rising edge.
- Step pending when the FSM enters IDLE: the step is discarded and step_ready_o returns to 1 in the IDLE cycle.
- edge_cnt_o increments in every cycle edge_o=1.
- Outputs ref_clk_o, edge_o and load_ack_o are all flop outputs. No combinational path from inputs.

Decomposition:
- Shared package ref_clk_gen_pkg holds:
  - the state enum constants (IDLE/HIGH/LOW);
  - DEFAULT_HALF;
  - a saturating signed-add helper function, reused by the loop-filter bench.
- One natural sub-module, phase_len_calc: combinational clamp/saturate of half_q+step to L. All sequencing stays in ref_clk_gen.

Test Plan:
- Reset, then enable_i=1 with DEFAULT_HALF=50 -> first edge_o 1 cycle later; period 100 cycles, 50 high / 50 low; edge_cnt_o=10 after 10 edges.
- Running at half=50, load_i with half_period_i=20 mid-HIGH -> current period completes at 50/50; load_ack_o pulses at the next rising edge; thereafter 20/20.
- Step +10 accepted during HIGH at half=20 -> that LOW lasts 30; rising-edge spacing becomes 50 once; step_ready_o low until that LOW ends; later periods 40.
- Step -30 at half=20 -> LOW clamped to 1 cycle; saturation at half=0xFFFF with step +127 gives LOW=0xFFFF.
- Load half_period_i=0 in IDLE -> load_ack_o next cycle; enable gives 1-high/1-low toggling.
- enable_i dropped mid-HIGH with a step pending -> HIGH and LOW complete, then IDLE with ref_clk_o=0, step discarded, step_ready_o=1. Asserting reset_i mid-LOW forces ref_clk_o=0 immediately.

Source files
------------

// File: rtl/ref_clk_gen_pkg.sv
// Shared definitions for the reference-clock generator: FSM states, reset
// half-period and a saturating signed add also used by the loop-filter bench.
package ref_clk_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [15:0] DEFAULT_HALF = 16'd50;

   // a + b, clamped to [lo, hi]; one guard bit keeps the sum exact
   function automatic logic signed [31:0] sat_add(
      input logic signed [31:0] a,
      input logic signed [31:0] b,
      input logic signed [31:0] lo,
      input logic signed [31:0] hi
   );
      logic signed [32:0] sum;
      sum = $signed({a[31], a}) + $signed({b[31], b});
      if (sum < $signed({lo[31], lo})) begin
         return lo;
      end
      if (sum > $signed({hi[31], hi})) begin
         return hi;
      end
      return sum[31:0];
   endfunction

endpackage

// File: rtl/ref_clk_gen_phase_len_calc.sv
// Length of a LOW phase: half-period plus optional signed step, held to
// at least one cycle and at most the largest counter value.
module phase_len_calc
   import ref_clk_gen_pkg::*;
#(
   parameter int PERIOD_WIDTH = 16,
   parameter int STEP_WIDTH   = 8
) (
   input  logic                         step_en,
   input  logic        [PERIOD_WIDTH-1:0] half,
   input  logic signed [STEP_WIDTH-1:0]   step,
   output logic        [PERIOD_WIDTH-1:0] len
);

   localparam logic signed [31:0] LEN_MIN = 32'sd1;
   localparam logic signed [31:0] LEN_MAX = (32'sd1 <<< PERIOD_WIDTH) - 32'sd1;

   logic signed [31:0] half_ext;
   logic signed [31:0] step_ext;

   always_comb begin
      half_ext = $signed({{(32-PERIOD_WIDTH){1'b0}}, half});
      step_ext = step_en ? 32'(step) : 32'sd0;
      len      = PERIOD_WIDTH'(sat_add(half_ext, step_ext, LEN_MIN, LEN_MAX));
   end

endmodule

// File: rtl/ref_clk_gen.sv
// Programmable reference-clock generator for the ADPLL: glitch-free
// half-period reloads and signed phase-step injection into LOW phases.
module ref_clk_gen #(
   parameter int                      PERIOD_WIDTH   = 16,
   parameter logic [PERIOD_WIDTH-1:0] DEFAULT_HALF   = PERIOD_WIDTH'(ref_clk_gen_pkg::DEFAULT_HALF),
   parameter int                      STEP_WIDTH     = 8,
   parameter int                      EDGE_CNT_WIDTH = 16
) (
   input  logic                        fpga_clk_i,
   input  logic                        reset_i,
   input  logic                        enable_i,
   input  logic [PERIOD_WIDTH-1:0]     half_period_i,
   input  logic                        load_i,
   output logic                        load_ack_o,
   input  logic signed [STEP_WIDTH-1:0] phase_step_i,
   input  logic                        step_valid_i,
   output logic                        step_ready_o,
   output logic                        ref_clk_o,
   output logic                        edge_o,
   output logic [EDGE_CNT_WIDTH-1:0]   edge_cnt_o
);

   import ref_clk_gen_pkg::*;

   localparam logic [PERIOD_WIDTH-1:0]   ONE  = PERIOD_WIDTH'(1);
   localparam logic [EDGE_CNT_WIDTH-1:0] EINC = EDGE_CNT_WIDTH'(1);

   state_t                        state_q, state_d;
   logic [PERIOD_WIDTH-1:0]       cnt_q, cnt_d;
   logic [PERIOD_WIDTH-1:0]       half_q, pend_half_q;
   logic [PERIOD_WIDTH-1:0]       low_len_q, low_len_d;
   logic                          load_pend_q;
   logic                          step_pend_q, step_used_q;
   logic signed [STEP_WIDTH-1:0]  step_val_q, step_eff;
   logic                          step_eff_en;
   logic                          rise, to_low, low_end, apply, accept;

   assign accept      = step_valid_i & step_ready_o;
   // a step accepted on the last HIGH cycle still shapes the LOW it enters
   assign step_eff_en = step_pend_q | accept;
   assign step_eff    = step_pend_q ? step_val_q : phase_step_i;

   phase_len_calc #(
      .PERIOD_WIDTH (PERIOD_WIDTH),
      .STEP_WIDTH   (STEP_WIDTH)
   ) u_len (
      .step_en (step_eff_en),
      .half    (half_q),
      .step    (step_eff),
      .len     (low_len_d)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + ONE;
      rise    = 1'b0;
      to_low  = 1'b0;
      low_end = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (enable_i) begin
               state_d = HIGH;
               rise    = 1'b1;
            end
         end
         HIGH: begin
            if (cnt_q == half_q - ONE) begin
               state_d = LOW;
               cnt_d   = '0;
               to_low  = 1'b1;
            end
         end
         LOW: begin
            // enable is only honoured at the end of a full LOW phase
            if (cnt_q == low_len_q - ONE) begin
               low_end = 1'b1;
               cnt_d   = '0;
               rise    = enable_i;
               state_d = enable_i ? HIGH : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // a pending half-period is adopted in IDLE or at a rising edge
   assign apply = load_pend_q & ((state_q == IDLE) | rise);

   // Stage: sequencing and registered clock outputs
   always_ff @(posedge fpga_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ref_clk_o  <= 1'b0;
         edge_o     <= 1'b0;
         edge_cnt_o <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ref_clk_o <= (state_d == HIGH);
         edge_o    <= rise;
         if (rise) begin
            edge_cnt_o <= edge_cnt_o + EINC;
         end
      end
   end

   // Stage: half-period reload handshake
   always_ff @(posedge fpga_clk_i or posedge reset_i) begin
      if (reset_i) begin
         half_q      <= DEFAULT_HALF;
         load_pend_q <= 1'b0;
         load_ack_o  <= 1'b0;
      end else begin
         load_ack_o <= apply;
         if (apply) begin
            half_q <= pend_half_q;
         end
         if (load_i) begin
            load_pend_q <= 1'b1;
         end else if (apply) begin
            load_pend_q <= 1'b0;
         end
      end
   end

   // Stage: phase-step slot
   always_ff @(posedge fpga_clk_i or posedge reset_i) begin
      if (reset_i) begin
         step_pend_q  <= 1'b0;
         step_used_q  <= 1'b0;
         step_ready_o <= 1'b1;
      end else if (low_end && (!enable_i || step_used_q)) begin
         step_pend_q  <= 1'b0;
         step_used_q  <= 1'b0;
         step_ready_o <= 1'b1;
      end else begin
         if (accept) begin
            step_pend_q  <= 1'b1;
            step_ready_o <= 1'b0;
         end
         if (to_low && step_eff_en) begin
            step_used_q <= 1'b1;
         end
      end
   end

   // Stage: data registers, no reset needed
   always_ff @(posedge fpga_clk_i) begin
      if (load_i) begin
         pend_half_q <= (half_period_i == '0) ? ONE : half_period_i;
      end
      if (accept) begin
         step_val_q <= phase_step_i;
      end
      if (to_low) begin
         low_len_q <= low_len_d;
      end
   end

endmodule

// File: tb/tb_ref_clk_gen.sv
// Bench for ref_clk_gen: directed scenarios plus random traffic, each cycle
// compared against a phase-countdown model of the generator's rules.
module tb_ref_clk_gen;

   localparam int PW    = 10;
   localparam int SW    = 8;
   localparam int ECW   = 4;
   localparam int MAXL  = (1 << PW) - 1;
   localparam int PH_IDLE = 0;
   localparam int PH_HIGH = 1;
   localparam int PH_LOW  = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 enable = 1'b0;
   logic [PW-1:0]        hp = '0;
   logic                 load = 1'b0;
   logic                 load_ack_o;
   logic signed [SW-1:0] step_r = '0;
   logic                 step_valid = 1'b0;
   logic                 step_ready_o;
   logic                 ref_clk_o;
   logic                 edge_o;
   logic [ECW-1:0]       edge_cnt_o;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_phase, m_left, m_half, m_pend_half, m_load_pend;
   int m_has_step, m_step_val, m_bound, m_ready;
   int m_clk, m_edge, m_ack, m_cnt;

   ref_clk_gen #(
      .PERIOD_WIDTH   (PW),
      .DEFAULT_HALF   (10'd50),
      .STEP_WIDTH     (SW),
      .EDGE_CNT_WIDTH (ECW)
   ) dut (
      .fpga_clk_i    (clk),
      .reset_i       (rst),
      .enable_i      (enable),
      .half_period_i (hp),
      .load_i        (load),
      .load_ack_o    (load_ack_o),
      .phase_step_i  (step_r),
      .step_valid_i  (step_valid),
      .step_ready_o  (step_ready_o),
      .ref_clk_o     (ref_clk_o),
      .edge_o        (edge_o),
      .edge_cnt_o    (edge_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = PH_IDLE; m_left = 0; m_half = 50; m_pend_half = 0; m_load_pend = 0;
      m_has_step = 0; m_step_val = 0; m_bound = 0; m_ready = 1;
      m_clk = 0; m_edge = 0; m_ack = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      int  len, sv, step_in;
      bit  rise, enter_low, end_low, apply, accept;
      step_in   = int'(step_r);
      accept    = step_valid && (m_ready == 1);
      rise      = 0;
      enter_low = 0;
      end_low   = 0;
      len       = 0;
      if (m_phase == PH_IDLE) begin
         rise = enable;
      end else if (m_left == 1) begin
         if (m_phase == PH_HIGH) enter_low = 1;
         else begin
            end_low = 1;
            rise    = enable;
         end
      end
      apply = (m_load_pend == 1) && (m_phase == PH_IDLE || rise);
      if (enter_low) begin
         sv = 0;
         if (m_has_step == 1) sv = m_step_val;
         else if (accept) sv = step_in;
         len = m_half + sv;
         if (len < 1) len = 1;
         if (len > MAXL) len = MAXL;
      end
      if (end_low && (!enable || m_bound == 1)) begin
         m_has_step = 0; m_bound = 0; m_ready = 1;
      end else begin
         if (enter_low && (m_has_step == 1 || accept)) m_bound = 1;
         if (accept) begin
            m_has_step = 1; m_step_val = step_in; m_ready = 0;
         end
      end
      if (apply) m_half = m_pend_half;
      m_ack = apply;
      if (load) begin
         m_pend_half = (hp == 0) ? 1 : int'(hp);
         m_load_pend = 1;
      end else if (apply) begin
         m_load_pend = 0;
      end
      if (rise) begin
         m_phase = PH_HIGH; m_left = m_half;
      end else if (enter_low) begin
         m_phase = PH_LOW; m_left = len;
      end else if (end_low) begin
         m_phase = PH_IDLE; m_left = 0;
      end else if (m_phase != PH_IDLE) begin
         m_left--;
      end
      m_clk  = (m_phase == PH_HIGH);
      m_edge = rise;
      if (rise) m_cnt = (m_cnt + 1) % (1 << ECW);
   endtask

   task automatic compare_all();
      chk("ref_clk",    int'(ref_clk_o),    m_clk);
      chk("edge",       int'(edge_o),       m_edge);
      chk("load_ack",   int'(load_ack_o),   m_ack);
      chk("step_ready", int'(step_ready_o), m_ready);
      chk("edge_cnt",   int'(edge_cnt_o),   m_cnt);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_phase(input int ph, input int limit);
      int n = 0;
      while (m_phase != ph && n < limit) begin
         tick();
         n++;
      end
      chk("wait_phase_timeout", m_phase, ph);
   endtask

   task automatic wait_ack(input int limit);
      int n = 0;
      while (load_ack_o !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      chk("wait_ack_timeout", int'(load_ack_o), 1);
   endtask

   task automatic send_step(input int v);
      step_r     = SW'(v);
      step_valid = 1'b1;
      tick();
      step_valid = 1'b0;
   endtask

   task automatic send_load(input int h);
      hp   = PW'(h);
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   initial begin
      int t;
      model_reset();
      run(3);
      chk("rst_ref_clk", int'(ref_clk_o),    0);
      chk("rst_ready",   int'(step_ready_o), 1);
      chk("rst_edgecnt", int'(edge_cnt_o),   0);
      rst = 1'b0;
      run(2);

      // default half-period: edges every 100 cycles
      enable = 1'b1;
      run(1);
      chk("first_edge", int'(edge_o), 1);
      run(999);
      chk("edge_cnt_10", int'(edge_cnt_o), 10);

      // reload mid-HIGH, then 20/20
      wait_phase(PH_HIGH, 200);
      run(10);
      send_load(20);
      wait_ack(200);
      run(3);
      send_step(10);
      chk("ready_low_after_step", int'(step_ready_o), 0);
      run(200);

      // large negative step clamps LOW to one cycle
      wait_phase(PH_LOW, 200);
      wait_phase(PH_HIGH, 200);
      run(2);
      send_step(-30);
      run(150);

      // saturation of LOW at the counter maximum
      send_load(MAXL);
      wait_ack(200);
      run(5);
      send_step(127);
      run(3200);

      // zero half-period loaded in IDLE, then 1/1 toggling
      enable = 1'b0;
      wait_phase(PH_IDLE, 5000);
      send_load(0);
      tick();
      chk("ack_in_idle", int'(load_ack_o), 1);
      enable = 1'b1;
      run(20);

      // enable dropped mid-HIGH with a step in flight
      send_load(20);
      wait_ack(20);
      run(3);
      send_step(5);
      run(2);
      enable = 1'b0;
      run(60);
      chk("idle_ready", int'(step_ready_o), 1);
      chk("idle_clk",   int'(ref_clk_o),    0);

      // random traffic
      enable = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) enable = ~enable;
         load       = ($urandom_range(0, 99) == 0);
         hp         = PW'($urandom_range(0, 30));
         step_valid = ($urandom_range(0, 14) == 0);
         t          = int'($urandom_range(0, 80)) - 40;
         step_r     = t[SW-1:0];
         tick();
      end
      load       = 1'b0;
      step_valid = 1'b0;

      // asynchronous reset in the middle of LOW
      enable = 1'b1;
      wait_phase(PH_LOW, 3000);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_clk", int'(ref_clk_o), 0);
      model_reset();
      compare_all();
      run(2);
      rst = 1'b0;
      run(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
